// File: rtl/servo_axis_scheduler.sv
// Servo axis scheduler: parses 3-byte UART position packets into per-axis targets
// and slews the X/Y driver positions toward them once per PWM frame, with a watchdog.
module servo_axis_scheduler #(
    parameter int FRAME_TICKS    = 360,
    parameter int STEP           = 8,
    parameter int CENTER         = 512,
    parameter int POS_MIN        = 0,
    parameter int POS_MAX        = 1023,
    parameter int TIMEOUT_FRAMES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       frame_tick,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       timeout
);

    localparam int CNT_W = $clog2(FRAME_TICKS);
    localparam int WD_W  = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    typedef enum logic [1:0] {IDLE, HDR, LO} parse_t;

    parse_t           state;
    logic             hdr_axis;
    logic [1:0]       hdr_hi;
    logic [9:0]       tgt_x;
    logic [9:0]       tgt_y;
    logic [CNT_W-1:0] frame_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             commit;
    logic [9:0]       rx_pos;

    function automatic logic [9:0] clamp(input logic [9:0] p);
        if (int'(p) < POS_MIN) return 10'(POS_MIN);
        if (int'(p) > POS_MAX) return 10'(POS_MAX);
        return p;
    endfunction

    // Targets are clamped, so a single bounded step toward them can never wrap.
    function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] tgt);
        logic signed [10:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (d <= STEP_S && d >= -STEP_S) return tgt;
        if (d > 11'sd0) return cur + 10'(STEP);
        return cur - 10'(STEP);
    endfunction

    assign frame_tick = (frame_cnt == CNT_W'(FRAME_TICKS - 1));
    assign commit     = rx_valid && (state == LO);
    assign pkt_ok     = commit;
    assign pkt_err    = rx_valid && (state == HDR) && (rx_data != 8'hFF) && (rx_data[7:3] != 5'b0);
    assign rx_pos     = {hdr_hi, rx_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hdr_axis <= 1'b0;
            hdr_hi   <= 2'b0;
        end else if (rx_valid) begin
            case (state)
                IDLE: if (rx_data == 8'hFF) state <= HDR;
                HDR: begin
                    if (rx_data == 8'hFF) begin
                        state <= HDR;
                    end else if (rx_data[7:3] == 5'b0) begin
                        {hdr_axis, hdr_hi} <= rx_data[2:0];
                        state              <= LO;
                    end else begin
                        state <= IDLE;
                    end
                end
                LO:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: non-blocking updates mean the slew below reads the pre-commit target,
    // so a commit landing on frame_tick only takes effect from the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            wd_cnt    <= '0;
            timeout   <= 1'b0;
            tgt_x     <= 10'(CENTER);
            tgt_y     <= 10'(CENTER);
            pos_x     <= 10'(CENTER);
            pos_y     <= 10'(CENTER);
        end else begin
            frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;

            if (frame_tick) begin
                pos_x <= slew(pos_x, tgt_x);
                pos_y <= slew(pos_y, tgt_y);
            end

            if (commit) begin
                wd_cnt  <= '0;
                timeout <= 1'b0;
                if (hdr_axis) tgt_y <= clamp(rx_pos);
                else          tgt_x <= clamp(rx_pos);
            end else if (frame_tick && wd_cnt != WD_W'(TIMEOUT_FRAMES)) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_W'(TIMEOUT_FRAMES - 1)) begin
                    tgt_x   <= 10'(CENTER);
                    tgt_y   <= 10'(CENTER);
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule
